// File: rtl/hand_pkg.sv
// Shared card and hand definitions for the seat accumulators and the game-control compare logic.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package hand_pkg;

  typedef logic [3:0] card_t;
  typedef logic [1:0] state_t;

  localparam card_t      CARD_INVALID    = 4'hF;
  localparam card_t      CARD_ACE        = 4'd1;
  localparam card_t      CARD_MAX        = 4'd10;
  localparam logic [4:0] BLACKJACK_VALUE = 5'd21;

  // Draw FSM encoding, kept as plain constants so older tools can share it
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_REQUEST = 2'd1;
  localparam state_t ST_ADD     = 2'd2;
  localparam state_t ST_CHECK   = 2'd3;

  // Deck values 1..10 are real cards; 0 and 11..15 mean "no card this cycle"
  function automatic logic card_is_valid(input card_t c);
    return (c >= CARD_ACE) && (c <= CARD_MAX);
  endfunction

endpackage

// File: rtl/hand_value.sv
// Scores a hand from its hard sum and ace flag: best total, soft indication and bust.
// Latency: purely combinational.
// Backpressure: none.
module hand_value
  import hand_pkg::*;
(
  input  logic [4:0] hard_sum,
  input  logic       has_ace,
  output logic [4:0] total,
  output logic       is_soft,
  output logic       bust
);

  logic soft_ok;

  // One ace may count as 11 only while that keeps the hand at or under 21
  assign soft_ok = has_ace && (hard_sum <= 5'd11);
  assign total   = soft_ok ? (hard_sum + 5'd10) : hard_sum;
  assign is_soft = soft_ok;
  assign bust    = hard_sum > BLACKJACK_VALUE;

endmodule

// File: rtl/hand_accumulator.sv
// Per-seat hand tracker: requests cards from the deck on newHand/hit and keeps the running hand state.
// Latency: hit -> requestCard next cycle, card and totals one cycle later, idle 4 cycles after hit.
// Backpressure: deck answers combinationally; invalid cards hold requestCard high for up to MAX_RETRY cycles.
module hand_accumulator
  import hand_pkg::*;
#(
  parameter int MAX_CARDS     = 8,
  parameter int INITIAL_CARDS = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       newHand,
  input  logic       hit,
  input  logic [3:0] dealtCard,
  output logic       requestCard,
  output logic [3:0] lastCard,
  output logic       cardValid,
  output logic [3:0] cardCount,
  output logic [4:0] total,
  output logic       isSoft,
  output logic       bust,
  output logic       blackjack,
  output logic       busy,
  output logic       error
);

  localparam logic [3:0] MAX_CNT   = 4'(MAX_CARDS);
  localparam logic [3:0] INIT_CNT  = 4'(INITIAL_CARDS);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY - 1);

  state_t     state;
  logic [4:0] hard_sum;
  logic       has_ace;
  logic [3:0] draws_left;
  logic [3:0] retry_cnt;
  logic       hit_ok;

  hand_value u_value (
    .hard_sum (hard_sum),
    .has_ace  (has_ace),
    .total    (total),
    .is_soft  (isSoft),
    .bust     (bust)
  );

  // Status decoded from registered state
  assign requestCard = (state == ST_REQUEST);
  assign busy        = (state != ST_IDLE);
  assign blackjack   = (cardCount == 4'd2) && (total == BLACKJACK_VALUE);
  assign hit_ok      = (cardCount >= INIT_CNT) && !bust && (cardCount < MAX_CNT);

  // Draw FSM and hand registers; the accepted card is folded in on the edge
  // leaving REQUEST so totals and cardValid appear together during ADD
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hard_sum   <= 5'd0;
      has_ace    <= 1'b0;
      cardCount  <= 4'd0;
      lastCard   <= 4'h0;
      cardValid  <= 1'b0;
      error      <= 1'b0;
      draws_left <= 4'd0;
      retry_cnt  <= 4'd0;
    end else begin
      cardValid <= 1'b0;
      if (newHand) begin
        // newHand overrides hit and aborts any draw in flight
        hard_sum   <= 5'd0;
        has_ace    <= 1'b0;
        cardCount  <= 4'd0;
        error      <= 1'b0;
        draws_left <= INIT_CNT;
        retry_cnt  <= 4'd0;
        state      <= ST_REQUEST;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hit && hit_ok) begin
              draws_left <= 4'd1;
              retry_cnt  <= 4'd0;
              state      <= ST_REQUEST;
            end
          end
          ST_REQUEST: begin
            if (card_is_valid(dealtCard)) begin
              hard_sum   <= hard_sum + {1'b0, dealtCard};
              has_ace    <= has_ace | (dealtCard == CARD_ACE);
              cardCount  <= cardCount + 4'd1;
              lastCard   <= dealtCard;
              cardValid  <= 1'b1;
              retry_cnt  <= 4'd0;
              draws_left <= draws_left - 4'd1;
              state      <= ST_ADD;
            end else if (retry_cnt == RETRY_LIM) begin
              // Deck keeps failing: give up on this draw, hand stays as it was
              error     <= 1'b1;
              retry_cnt <= 4'd0;
              state     <= ST_IDLE;
            end else begin
              retry_cnt <= retry_cnt + 4'd1;
            end
          end
          ST_ADD: begin
            state <= ST_CHECK;
          end
          default: begin
            if ((draws_left != 4'd0) && !bust && (cardCount < MAX_CNT)) state <= ST_REQUEST;
            else state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hand_accumulator.md
Name: hand_accumulator

Overview:
- Consumer end of the card-deck interface: raises requestCard, captures the card value the deck returns, and keeps one hand's running state.
- Running state: card count, hard/soft total, ace handling, bust and blackjack flags.
- One instance per seat (player, dealer); the game-control FSM drives it with newHand/hit pulses and reads its status.

Parameters:
- MAX_CARDS, 8, maximum cards held; hits are refused once reached.
- INITIAL_CARDS, 2, cards auto-drawn after newHand.
- MAX_RETRY, 3, consecutive invalid cards tolerated per draw before the error flag sets.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- newHand  in  1  pulse: clear hand and auto-draw INITIAL_CARDS
- hit  in  1  pulse: draw one card
- dealtCard  in  4  card value from deck (1..10 valid; 4'hF = invalid/no card)
- requestCard  out  1  request to deck; deck output is valid combinationally while high
- lastCard  out  4  most recent accepted card
- cardValid  out  1  one-cycle pulse when a card is accepted
- cardCount  out  4  cards in hand
- total  out  5  best hand value (soft if it does not exceed 21)
- isSoft  out  1  total counts an ace as 11
- bust  out  1  hard total > 21
- blackjack  out  1  cardCount==2 and total==21
- busy  out  1  FSM not in IDLE
- error  out  1  sticky: MAX_RETRY consecutive invalid cards seen

Behaviour:
- Reset: every output is 0, lastCard 4'h0, FSM in IDLE. Reset mid-draw abandons the draw; requestCard is 0 on the next cycle.
- States: IDLE, REQUEST, ADD, CHECK.
- IDLE:
  - newHand clears hardSum, hasAce, cardCount, bust, blackjack and error, loads drawsLeft=INITIAL_CARDS, then goes to REQUEST.
  - hit is accepted only if cardCount>=INITIAL_CARDS, !bust and cardCount<MAX_CARDS. An accepted hit loads drawsLeft=1 and goes to REQUEST. A refused hit is ignored with no flag.
- REQUEST:
  - requestCard=1 for exactly this cycle; dealtCard is sampled at the clock edge ending the cycle.
  - Valid value (1..10): register the value and go to ADD.
  - Invalid value (0 or 11..15): increment retryCnt and stay in REQUEST, so requestCard stays high the next cycle.
  - When retryCnt reaches MAX_RETRY: set error and go to IDLE, leaving the hand unchanged.
- ADD (one cycle):
  - hardSum += card; hasAce |= (card==1); cardCount++; lastCard=card; cardValid=1; retryCnt=0; drawsLeft--.
- CHECK:
  - If drawsLeft!=0 and !bust and cardCount<MAX_CARDS, go to REQUEST; otherwise go to IDLE.
- Latency: hit at cycle N gives requestCard at N+1, cardValid and updated totals at N+2, and busy low at N+4. newHand with no retries gives both cards by N+5 and busy low at N+7.
- Arithmetic:
  - hardSum is 5 bits unsigned. Max reachable is 31 (21 plus a 10), so it never wraps.
  - total = (hasAce && hardSum<=11) ? hardSum+10 : hardSum.
  - isSoft is 1 exactly when the +10 applies.
  - bust = hardSum>21.
  - total, isSoft, bust and blackjack are combinational from the registered state.
- Simultaneous events:
  - newHand and hit in the same cycle: newHand wins.
  - newHand while busy: aborts the current draw, clears the hand, restarts the initial draw next cycle.
  - hit while busy is ignored.
- Once bust or cardCount==MAX_CARDS, the hand is frozen until newHand or reset.

Decomposition:
- Shared package hand_pkg:
  - card_t (4-bit), CARD_INVALID=4'hF, CARD_ACE=4'd1, CARD_MAX=4'd10, BLACKJACK_VALUE=5'd21.
  - The FSM state enum.
- One natural sub-module, hand_value: combinational (hardSum, hasAce) -> (total, isSoft, bust). It is reusable by the game-control compare logic.

Test Plan:
- Reset then newHand, deck returns 1 then 10 -> cardCount=2, total=21, isSoft=1, blackjack=1, busy low 7 cycles after newHand.
- newHand with 9, 7, then hit returning 8 -> total=24, bust=1, isSoft=0, blackjack=0; a further hit gives requestCard held 0.
- Aces: newHand with 1, 1, then hit returning 9 -> hardSum=11, total=21, isSoft=1; hit returning 5 -> total=16, isSoft=0.
- Invalid retry: during a hit the deck returns 4'hF twice then 6 -> requestCard high 3 consecutive cycles, one cardValid, error=0. Returning 4'hF three times -> error=1, cardCount unchanged, FSM back in IDLE.
- Simultaneous: newHand and hit in the same cycle -> only the 2-card initial draw occurs. newHand asserted during REQUEST of a hit -> hand cleared, cardCount ends at 2.
- Capacity: eight hits of card 2 after a 2,2 start -> cardCount stops at 8, total=16, further hits ignored. Reset asserted mid-REQUEST -> all outputs 0 next cycle.
